conv_window_ctrl: RTL and testbench
===================================

# conv_window_ctrl

Parametrised control path for the line-buffer convolver. It tracks the raster position (row, column, channel) of incoming pixels and asserts `enable` exactly when the datapath holds a complete KERNEL_SIZE×KERNEL_SIZE window at a stride-aligned position. Compared with the fixed single-channel, stride-1 control path, it adds:
- configurable stride;
- non-square images;
- interleaved multi-channel input;
- frame start/done handshakes.

It sits beside the convolver datapath and gates its accumulator/output register.

## Interface
Parameters:
- KERNEL_SIZE, 5, window edge length K (≥1, ≤ both image dimensions)
- IMAGE_WIDTH, 28, pixels per row W
- IMAGE_HEIGHT, 28, rows per frame H
- STRIDE, 1, window step in both directions S (≥1)
- CHANNELS, 1, pixels per raster position C, channel-interleaved (ch 0..C-1 consecutively)

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  begin a new frame (sampled in IDLE only)
- pixel_valid  in  1  datapath accepts one pixel this cycle
- enable  out  1  window complete for the pixel accepted last cycle
- last_ch  out  1  qualifies `enable`: pixel was channel C-1
- busy  out  1  frame in progress (state RUN)
- frame_done  out  1  one-cycle pulse after final pixel of frame
- out_row  out  clog2(OUT_H)  output-map row of current window (macro-gated)
- out_col  out  clog2(OUT_W)  output-map column of current window (macro-gated)

Derived: OUT_W = (W−K)/S+1, OUT_H = (H−K)/S+1 (integer division). Counter widths are clog2 of the respective range, minimum 1.

## Operation
- Single clock; one synchronous, active-high reset.
- States:
  - IDLE: start=1 → RUN, all counters cleared.
  - RUN: counts accepted pixels. Acceptance of pixel (H−1, W−1, C−1) → DONE.
  - DONE: unconditionally → IDLE after one cycle.
- Counters advance only on pixel_valid in RUN:
  - ch wraps C−1→0 and carries into col.
  - col wraps W−1→0 and carries into row.
- Stride phase counters (no modulo/divide):
  - rphase counts 0..S−1, starts at row K−1, resets on row wrap.
  - cphase counts 0..S−1, starts at col K−1, resets on col wrap.
- Window-valid condition for accepted pixel (r,c,ch): r≥K−1 and c≥K−1 and rphase==0 and cphase==0.
- Registered outputs:
  - enable is set for one cycle after a valid-window pixel is accepted (every channel).
  - last_ch = enable and ch==C−1.
- Residual columns/rows beyond the last aligned window (when (W−K)%S≠0) never raise enable.
- Ignored inputs:
  - pixel_valid in IDLE/DONE.
  - start in RUN/DONE.
- busy=1 in RUN only.
- frame_done=1 in DONE only.

## Timing
- Reset: state=IDLE, all counters 0, enable=0, last_ch=0, busy=0, frame_done=0, out_row=0, out_col=0.
- rst mid-frame: next cycle identical to post-reset, no frame_done, any pending enable dropped.
- Latency:
  - pixel_valid at edge n → enable/last_ch valid during cycle n+1.
  - start at edge n → busy=1 at n+1. A pixel_valid in that same start cycle is ignored.
- Final pixel accepted at edge n:
  - its enable (if aligned) and busy=0 with frame_done=1 during n+1.
  - IDLE at n+2; start honoured from n+2.
- Back-to-back pixel_valid every cycle is supported; gaps stall counters with no effect on correctness.

## Configuration
- Macro CONV_WINDOW_CTRL_OUTCOORD_EN.
- Defined: out_row/out_col ports and counters are present, registered alongside enable.
  - out_col increments after each enable with last_ch, wrapping at OUT_W−1 and carrying into out_row.
  - Both clear on start and reset.
- Undefined: ports and counters are absent; all other behaviour is unchanged.

## Test plan
- K=5, W=H=28, S=1, C=1, continuous pixel_valid after start:
  - first enable one cycle after 117th pixel (r4,c4);
  - 576 enables total;
  - frame_done one cycle after pixel 784.
- S=2, same image → 144 enables (12×12); no enable for columns/rows 27 (residual); with macro, last window out_row=11, out_col=11.
- C=3, S=1 → 1728 enables, 576 with last_ch; enables only in 3-cycle groups at aligned positions.
- Random pixel_valid gaps (≈50% duty), W=30, H=20, K=3, S=2 → enable count 14×9=126 and positions match a reference model.
- rst asserted at pixel 300, then start → no frame_done from aborted frame; new frame yields full 576 enables.
- start pulsed during RUN and pixel_valid during IDLE → no counter change; enable count unaffected.

Source files
------------

// File: rtl/conv_window_ctrl.sv
// conv_window_ctrl: control path for the line-buffer convolver.
// Tracks the raster position (row, col, channel) of accepted pixels and pulses
// enable when the datapath holds a complete KxK window at a stride-aligned spot.
// Optional output-map coordinates: define CONV_WINDOW_CTRL_OUTCOORD_EN.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for start; pixel_valid ignored
// RUN     | counting accepted pixels; busy=1
// DONE    | one-cycle frame_done pulse, then back to IDLE
module conv_window_ctrl #(
    parameter int KERNEL_SIZE  = 5,
    parameter int IMAGE_WIDTH  = 28,
    parameter int IMAGE_HEIGHT = 28,
    parameter int STRIDE       = 1,
    parameter int CHANNELS     = 1
`ifdef CONV_WINDOW_CTRL_OUTCOORD_EN
    ,
    localparam int OUT_W     = (IMAGE_WIDTH - KERNEL_SIZE) / STRIDE + 1,
    localparam int OUT_H     = (IMAGE_HEIGHT - KERNEL_SIZE) / STRIDE + 1,
    localparam int OROW_BITS = (OUT_H > 1) ? $clog2(OUT_H) : 1,
    localparam int OCOL_BITS = (OUT_W > 1) ? $clog2(OUT_W) : 1
`endif
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic pixel_valid,
    output logic enable,
    output logic last_ch,
    output logic busy,
    output logic frame_done
`ifdef CONV_WINDOW_CTRL_OUTCOORD_EN
    ,
    output logic [OROW_BITS-1:0] out_row,
    output logic [OCOL_BITS-1:0] out_col
`endif
);

    localparam int CH_BITS  = (CHANNELS > 1)     ? $clog2(CHANNELS)     : 1;
    localparam int COL_BITS = (IMAGE_WIDTH > 1)  ? $clog2(IMAGE_WIDTH)  : 1;
    localparam int ROW_BITS = (IMAGE_HEIGHT > 1) ? $clog2(IMAGE_HEIGHT) : 1;
    localparam int PH_BITS  = (STRIDE > 1)       ? $clog2(STRIDE)       : 1;

    localparam logic [CH_BITS-1:0]  CH_MAX  = CH_BITS'(CHANNELS - 1);
    localparam logic [COL_BITS-1:0] COL_MAX = COL_BITS'(IMAGE_WIDTH - 1);
    localparam logic [ROW_BITS-1:0] ROW_MAX = ROW_BITS'(IMAGE_HEIGHT - 1);
    localparam logic [COL_BITS-1:0] COL_KM1 = COL_BITS'(KERNEL_SIZE - 1);
    localparam logic [ROW_BITS-1:0] ROW_KM1 = ROW_BITS'(KERNEL_SIZE - 1);
    localparam logic [PH_BITS-1:0]  PH_MAX  = PH_BITS'(STRIDE - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t              state_q;
    logic [CH_BITS-1:0]  ch_q, ch_d;
    logic [COL_BITS-1:0] col_q, col_d;
    logic [ROW_BITS-1:0] row_q, row_d;
    logic [PH_BITS-1:0]  rphase_q, rphase_d;
    logic [PH_BITS-1:0]  cphase_q, cphase_d;
    logic                enable_q, last_ch_q, busy_q, done_q;

    logic accept, ch_wrap, col_wrap, row_wrap, win_ok, frame_last;

    // Phase advances modulo STRIDE without a divider.
    function automatic logic [PH_BITS-1:0] ph_step(input logic [PH_BITS-1:0] ph);
        return (ph == PH_MAX) ? '0 : ph + PH_BITS'(1);
    endfunction

    // Decode the raster position of the pixel offered this cycle
    always_comb begin
        accept     = (state_q == ST_RUN) && pixel_valid;
        ch_wrap    = (ch_q == CH_MAX);
        col_wrap   = (col_q == COL_MAX);
        row_wrap   = (row_q == ROW_MAX);
        win_ok     = (row_q >= ROW_KM1) && (col_q >= COL_KM1) &&
                     (rphase_q == '0) && (cphase_q == '0);
        frame_last = accept && ch_wrap && col_wrap && row_wrap;
    end

    // Next raster position and stride phases for an accepted pixel
    always_comb begin
        ch_d     = ch_q;
        col_d    = col_q;
        row_d    = row_q;
        rphase_d = rphase_q;
        cphase_d = cphase_q;
        if (accept) begin
            if (ch_wrap) begin
                ch_d = '0;
                if (col_wrap) begin
                    col_d    = '0;
                    cphase_d = '0;
                    if (row_wrap) begin
                        row_d    = '0;
                        rphase_d = '0;
                    end else begin
                        row_d    = row_q + ROW_BITS'(1);
                        // phase only starts counting once the window bottom edge is reached
                        rphase_d = (row_q >= ROW_KM1) ? ph_step(rphase_q) : '0;
                    end
                end else begin
                    col_d    = col_q + COL_BITS'(1);
                    cphase_d = (col_q >= COL_KM1) ? ph_step(cphase_q) : '0;
                end
            end else begin
                ch_d = ch_q + CH_BITS'(1);
            end
        end
    end

    // Frame sequencer with raster counters and registered window/handshake flags
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            ch_q      <= '0;
            col_q     <= '0;
            row_q     <= '0;
            rphase_q  <= '0;
            cphase_q  <= '0;
            enable_q  <= 1'b0;
            last_ch_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            enable_q  <= accept && win_ok;
            last_ch_q <= accept && win_ok && ch_wrap;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q  <= ST_RUN;
                        busy_q   <= 1'b1;
                        ch_q     <= '0;
                        col_q    <= '0;
                        row_q    <= '0;
                        rphase_q <= '0;
                        cphase_q <= '0;
                    end
                end
                ST_RUN: begin
                    ch_q     <= ch_d;
                    col_q    <= col_d;
                    row_q    <= row_d;
                    rphase_q <= rphase_d;
                    cphase_q <= cphase_d;
                    if (frame_last) begin
                        state_q <= ST_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign enable     = enable_q;
    assign last_ch    = last_ch_q;
    assign busy       = busy_q;
    assign frame_done = done_q;

`ifdef CONV_WINDOW_CTRL_OUTCOORD_EN
    localparam logic [OROW_BITS-1:0] OROW_MAX = OROW_BITS'(OUT_H - 1);
    localparam logic [OCOL_BITS-1:0] OCOL_MAX = OCOL_BITS'(OUT_W - 1);

    logic [OROW_BITS-1:0] out_row_q;
    logic [OCOL_BITS-1:0] out_col_q;

    // Output-map coordinate; steps once all channels of a window have been flagged
    always_ff @(posedge clk) begin
        if (rst || ((state_q == ST_IDLE) && start)) begin
            out_row_q <= '0;
            out_col_q <= '0;
        end else if (enable_q && last_ch_q) begin
            if (out_col_q == OCOL_MAX) begin
                out_col_q <= '0;
                out_row_q <= (out_row_q == OROW_MAX) ? '0 : out_row_q + OROW_BITS'(1);
            end else begin
                out_col_q <= out_col_q + OCOL_BITS'(1);
            end
        end
    end

    assign out_row = out_row_q;
    assign out_col = out_col_q;
`endif

endmodule

// File: tb/tb_conv_window_ctrl.sv
// Scoreboard bench for conv_window_ctrl: a raster reference model pushes the
// expected per-cycle state and window flags; a negedge monitor pops and compares.
module tb_conv_window_ctrl;
    localparam int K = 3;
    localparam int W = 12;
    localparam int H = 8;
    localparam int S = 2;
    localparam int C = 3;
    localparam int OUT_W  = (W - K) / S + 1;
    localparam int OUT_H  = (H - K) / S + 1;
    localparam int NPIX   = W * H * C;
    localparam int EXP_EN = OUT_W * OUT_H * C;
    localparam int EXP_LC = OUT_W * OUT_H;
    localparam int ORB = (OUT_H > 1) ? $clog2(OUT_H) : 1;
    localparam int OCB = (OUT_W > 1) ? $clog2(OUT_W) : 1;

    logic clk = 1'b0;
    logic rst, start, pixel_valid;
    logic enable, last_ch, busy, frame_done;
`ifdef CONV_WINDOW_CTRL_OUTCOORD_EN
    logic [ORB-1:0] out_row;
    logic [OCB-1:0] out_col;
`endif

    conv_window_ctrl #(
        .KERNEL_SIZE(K), .IMAGE_WIDTH(W), .IMAGE_HEIGHT(H), .STRIDE(S), .CHANNELS(C)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .pixel_valid(pixel_valid),
        .enable(enable), .last_ch(last_ch), .busy(busy), .frame_done(frame_done)
`ifdef CONV_WINDOW_CTRL_OUTCOORD_EN
        , .out_row(out_row), .out_col(out_col)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int cyc; bit busy; bit fd; bit rchk; } st_t;
    typedef struct { int cyc; bit lc; int orow; int ocol; } en_t;
    st_t st_q[$];
    en_t en_q[$];

    // reference model state: 0 idle, 1 run, 2 done; m_p = pixels accepted this frame
    int m_state = 0;
    int m_p     = 0;
    bit mon_en  = 1'b0;

    int n_cmp = 0;
    int n_err = 0;
    int fr_en = 0;
    int fr_lc = 0;
    logic busy_prev = 1'b0;

    task automatic step(input bit r, input bit s, input bit v);
        int e, ch, pos, rr, cc;
        st_t se;
        en_t ee;
        rst = r; start = s; pixel_valid = v;
        e = cyc + 1;
        if (r) m_state = 0;
        else begin
            case (m_state)
                0: if (s) begin m_state = 1; m_p = 0; end
                1: if (v) begin
                    ch  = m_p % C;
                    pos = m_p / C;
                    cc  = pos % W;
                    rr  = pos / W;
                    if (rr >= K-1 && cc >= K-1 && (rr-(K-1)) % S == 0 && (cc-(K-1)) % S == 0) begin
                        ee.cyc  = e;
                        ee.lc   = (ch == C-1);
                        ee.orow = (rr-(K-1)) / S;
                        ee.ocol = (cc-(K-1)) / S;
                        en_q.push_back(ee);
                    end
                    m_p++;
                    if (m_p == NPIX) m_state = 2;
                end
                default: m_state = 0;
            endcase
        end
        se.cyc = e; se.busy = (m_state == 1); se.fd = (m_state == 2); se.rchk = r;
        st_q.push_back(se);
        @(posedge clk); #1;
    endtask

    function automatic bit rbit();
        return 1'($urandom % 2);
    endfunction

    task automatic run_frame(input int duty, input bit noise, input bit pv_at_start);
        int guard = 0;
        step(1'b0, 1'b1, pv_at_start);
        while (m_state != 2 && guard < NPIX * 20) begin
            step(1'b0, noise && ($urandom % 6 == 0), int'($urandom_range(99, 0)) < duty);
            guard++;
        end
        step(1'b0, noise ? 1'b1 : 1'b0, rbit());  // DONE cycle: start must be ignored
        step(1'b0, 1'b0, rbit());
    endtask

    task automatic abort_frame(input int p_abort);
        step(1'b0, 1'b1, 1'b0);
        while (m_p < p_abort) step(1'b0, 1'b0, rbit());
        step(1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0);
    endtask

    // Monitor: compare state flags and window flags against the scoreboard
    always @(negedge clk) begin
        st_t se;
        en_t ee;
        if (mon_en) begin
            if (busy === 1'b1 && busy_prev !== 1'b1) begin fr_en = 0; fr_lc = 0; end
            busy_prev = busy;
            if (st_q.size() > 0 && st_q[0].cyc == cyc) begin
                se = st_q.pop_front();
                n_cmp++;
                if (busy !== se.busy || frame_done !== se.fd) begin
                    n_err++;
                    $display("FAIL state cyc=%0d busy=%b frame_done=%b expected busy=%b frame_done=%b",
                             cyc, busy, frame_done, se.busy, se.fd);
                end
                if (se.rchk) begin
                    n_cmp++;
                    if (enable !== 1'b0 || last_ch !== 1'b0
`ifdef CONV_WINDOW_CTRL_OUTCOORD_EN
                        || out_row !== '0 || out_col !== '0
`endif
                       ) begin
                        n_err++;
                        $display("FAIL reset_outputs cyc=%0d enable=%b last_ch=%b expected all zero",
                                 cyc, enable, last_ch);
                    end
                end
            end
            while (en_q.size() > 0 && en_q[0].cyc < cyc) begin
                ee = en_q.pop_front();
                n_cmp++; n_err++;
                $display("FAIL missing_enable cyc=%0d got enable=0 expected enable=1", ee.cyc);
            end
            if (enable === 1'b1) begin
                n_cmp++;
                if (en_q.size() > 0 && en_q[0].cyc == cyc) begin
                    ee = en_q.pop_front();
                    if (last_ch !== ee.lc
`ifdef CONV_WINDOW_CTRL_OUTCOORD_EN
                        || out_row !== ORB'(ee.orow) || out_col !== OCB'(ee.ocol)
`endif
                       ) begin
                        n_err++;
                        $display("FAIL enable_payload cyc=%0d last_ch=%b expected %b (row/col exp %0d/%0d)",
                                 cyc, last_ch, ee.lc, ee.orow, ee.ocol);
                    end
                end else begin
                    n_err++;
                    $display("FAIL unexpected_enable cyc=%0d got enable=1 expected enable=0", cyc);
                end
                fr_en++;
                if (last_ch === 1'b1) fr_lc++;
            end else begin
                n_cmp++;
                if (last_ch !== 1'b0) begin
                    n_err++;
                    $display("FAIL last_ch_without_enable cyc=%0d got last_ch=%b expected 0", cyc, last_ch);
                end
            end
            if (frame_done === 1'b1) begin
                n_cmp++;
                if (fr_en != EXP_EN || fr_lc != EXP_LC) begin
                    n_err++;
                    $display("FAIL frame_counts cyc=%0d enables=%0d last_ch=%0d expected %0d/%0d",
                             cyc, fr_en, fr_lc, EXP_EN, EXP_LC);
                end
            end
        end
    end

    initial begin
        rst = 1'b1; start = 1'b0; pixel_valid = 1'b0;
        @(posedge clk); #1;
        mon_en = 1'b1;
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1);                 // start/pixel under reset ignored
        repeat (4) step(1'b0, 1'b0, rbit());    // pixel_valid in IDLE ignored
        run_frame(100, 1'b0, 1'b1);             // continuous, pixel in start cycle ignored
        run_frame(50, 1'b1, 1'b0);              // gaps plus spurious starts in RUN
        abort_frame(int'($urandom_range(NPIX - 40, 60)));
        run_frame(100, 1'b0, 1'b0);             // full frame after abort
        for (int i = 0; i < 3; i++) begin
            run_frame(int'($urandom_range(80, 30)), 1'b1, rbit());
            repeat (int'($urandom_range(3, 0))) step(1'b0, 1'b0, rbit());
        end
        repeat (6) step(1'b0, 1'b0, 1'b0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
